// File: rtl/tt_shim_pkg.sv
// Shared types and helpers for the tt_stim_shim stimulus/check shim.
// Holds the run-state enum, the idle opcode and small arithmetic helpers.
package tt_shim_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [5:0] NOP_DEFAULT = 6'd0;

   // One FIFO entry packs {instr, expect, check}.
   function automatic int entry_w(input int instr_w, input int io_w);
      return instr_w + io_w + 1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tt_stim_shim_if.sv
// Load, control, core-facing and status signals of the shim in one bundle.
// master = bench side, slave = shim side.
interface tt_stim_shim_if #(
   parameter int INSTR_W = 6,
   parameter int IO_W    = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [IO_W-1:0]    in_expect;
   logic               in_check;
   logic               start;
   logic [INSTR_W-1:0] dut_instr;
   logic [IO_W-1:0]    dut_io;
   logic               busy;
   logic               done;
   logic               err_flag;
   logic [7:0]         err_count;
   logic [15:0]        first_err_idx;
   logic [15:0]        issue_count;

   modport master (
      output in_valid, in_instr, in_expect, in_check, start, dut_io,
      input  in_ready, dut_instr, busy, done, err_flag, err_count,
             first_err_idx, issue_count
   );

   modport slave (
      input  in_valid, in_instr, in_expect, in_check, start, dut_io,
      output in_ready, dut_instr, busy, done, err_flag, err_count,
             first_err_idx, issue_count
   );
endinterface

// File: rtl/tt_shim_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry.
// Storage is not reset; only pointers and occupancy are.
module tt_shim_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push;
   logic             pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

endmodule

// File: rtl/tt_stim_shim.sv
// Stimulus/check shim: buffers {instr, expect, check}, issues one instr per cycle
// to the core and compares io_out LAT cycles later, accumulating run statistics.
module tt_stim_shim
   import tt_shim_pkg::*;
#(
   parameter int INSTR_W = 6,
   parameter int IO_W    = 8,
   parameter int DEPTH   = 16,
   parameter int LAT     = 1,
   parameter logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_DEFAULT)
) (
   input  logic          clk,
   input  logic          rst,
   tt_stim_shim_if.slave bus
);
   localparam int EW = entry_w(INSTR_W, IO_W);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

   state_t             state_q, state_d;
   logic               fifo_full, fifo_empty;
   logic [AW:0]        fifo_cnt;
   logic [EW-1:0]      rd_entry;
   logic [INSTR_W-1:0] rd_instr;
   logic [IO_W-1:0]    rd_expect;
   logic               rd_check;
   logic               push, pop, launch, mis;
   logic [DW-1:0]      drain_cnt;
   logic [INSTR_W-1:0] dut_instr_q;
   logic               err_flag_q;
   logic [7:0]         err_cnt_q;
   logic [15:0]        first_idx_q;
   logic [15:0]        issue_cnt_q;
   logic               vld_p [LAT];
   logic [IO_W-1:0]    exp_p [LAT];
   logic [15:0]        idx_p [LAT];

   assign push         = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !fifo_full;
   assign {rd_instr, rd_expect, rd_check} = rd_entry;

   tt_shim_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data ({bus.in_instr, bus.in_expect, bus.in_check}),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (bus.start) state_d = fifo_empty ? S_DRAIN : S_RUN;
         // Leave RUN only when the pop empties the FIFO and nothing refills it.
         S_RUN: if (fifo_empty || (fifo_cnt == (AW+1)'(1) && !push)) state_d = S_DRAIN;
         S_DRAIN: if (drain_cnt == DW'(LAT-1)) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop      = (state_q == S_RUN) && !fifo_empty;
      launch   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
      bus.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
      bus.done = (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst || state_q != S_DRAIN) drain_cnt <= '0;
      else                            drain_cnt <= drain_cnt + 1'b1;
   end

   // p0: issue register and head of the check pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         dut_instr_q <= NOP;
         for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
      end else begin
         dut_instr_q <= pop ? rd_instr : NOP;
         vld_p[0]    <= pop && rd_check;
         for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      exp_p[0] <= rd_expect;
      idx_p[0] <= issue_cnt_q;
      for (int i = 1; i < LAT; i++) begin
         exp_p[i] <= exp_p[i-1];
         idx_p[i] <= idx_p[i-1];
      end
   end

   // p(LAT-1): compare against the core output and update run statistics
   assign mis = vld_p[LAT-1] && (bus.dut_io != exp_p[LAT-1]);

   always_ff @(posedge clk) begin
      if (rst || launch) begin
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         first_idx_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         if (pop) issue_cnt_q <= issue_cnt_q + 16'd1;
         if (mis) begin
            err_flag_q <= 1'b1;
            err_cnt_q  <= sat_inc8(err_cnt_q);
            if (!err_flag_q) first_idx_q <= idx_p[LAT-1];
         end
      end
   end

   assign bus.dut_instr     = dut_instr_q;
   assign bus.err_flag      = err_flag_q;
   assign bus.err_count     = err_cnt_q;
   assign bus.first_err_idx = first_idx_q;
   assign bus.issue_count   = issue_cnt_q;

endmodule

// File: tb/tb_tt_stim_shim.sv
// Self-checking bench for tt_stim_shim; a behavioural core model drives dut_io
// and run results are predicted from the entry lists the bench generates.
module tb_tt_stim_shim;
   localparam int INSTR_W = 6;
   localparam int IO_W    = 8;
   localparam int DEPTH   = 16;
   localparam int LAT     = 1;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   tt_stim_shim_if #(.INSTR_W(INSTR_W), .IO_W(IO_W)) bus ();

   tt_stim_shim #(.INSTR_W(INSTR_W), .IO_W(IO_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for the core: io_out is a fixed function of the current instruction.
   function automatic logic [7:0] core_fn(input logic [5:0] i);
      return {2'b00, i} * 8'd3 + 8'd7;
   endfunction

   assign bus.dut_io = core_fn(bus.dut_instr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] ins, input logic [7:0] ex, input logic ck, output bit ok);
      int n = 0;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      ok = bus.in_ready;
      bus.in_valid  = ok;
      bus.in_instr  = ins;
      bus.in_expect = ex;
      bus.in_check  = ck;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (!bus.done && n < budget) begin tick(); n++; end
      ok = bus.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      total++; if (bus.dut_instr !== 6'd0) begin bad++; $display("FAIL reset_instr got=%0d want=0", bus.dut_instr); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready); end
      total++; if ({bus.busy, bus.done, bus.err_flag} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.err_flag}); end
      total++; if (bus.err_count !== 8'd0 || bus.first_err_idx !== 16'd0 || bus.issue_count !== 16'd0) begin
         bad++; $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", bus.err_count, bus.first_err_idx, bus.issue_count);
      end
   endtask

   task automatic test_pass_run();
      bit ok;
      for (int i = 1; i <= 4; i++) load(6'(i), core_fn(6'(i)), 1'b1, ok);
      pulse_start();
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++; if (bus.dut_instr !== 6'(i)) begin bad++; $display("FAIL pass_issue%0d got=%0d want=%0d", i, bus.dut_instr, i); end
      end
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL pass_drain got=busy%0b/done%0b want=1/0", bus.busy, bus.done); end
      repeat (LAT) tick();
      total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL pass_done got=done%0b/busy%0b want=1/0", bus.done, bus.busy); end
      total++; if (bus.err_count !== 8'd0 || bus.err_flag !== 1'b0) begin bad++; $display("FAIL pass_errs got=%0d want=0", bus.err_count); end
      total++; if (bus.issue_count !== 16'd4) begin bad++; $display("FAIL pass_issue_count got=%0d want=4", bus.issue_count); end
      total++; if (bus.dut_instr !== 6'd0) begin bad++; $display("FAIL pass_nop got=%0d want=0", bus.dut_instr); end
   endtask

   task automatic test_mismatch();
      bit ok;
      logic [5:0] ins;
      logic [7:0] ex;
      for (int i = 0; i < 8; i++) begin
         ins = 6'(i + 10);
         ex  = core_fn(ins);
         if (i == 2 || i == 5 || i == 3) ex = ex ^ 8'h01;
         load(ins, ex, (i != 3), ok);
      end
      pulse_start();
      wait_done(40, ok);
      total++; if (!ok) begin bad++; $display("FAIL mis_timeout got=done0 want=done1"); end
      total++; if (bus.err_flag !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0b want=1", bus.err_flag); end
      total++; if (bus.err_count !== 8'd2) begin bad++; $display("FAIL mis_count got=%0d want=2", bus.err_count); end
      total++; if (bus.first_err_idx !== 16'd2) begin bad++; $display("FAIL mis_first got=%0d want=2", bus.first_err_idx); end
      total++; if (bus.issue_count !== 16'd8) begin bad++; $display("FAIL mis_issue got=%0d want=8", bus.issue_count); end
   endtask

   task automatic test_random(input int runs);
      bit ok;
      logic [5:0] ins [16];
      logic [7:0] exs [16];
      logic       cks [16];
      int n, errs, first;
      bit wrong;
      for (int r = 0; r < runs; r++) begin
         n = $urandom_range(1, 16);
         errs = 0; first = -1;
         for (int i = 0; i < n; i++) begin
            ins[i] = 6'($urandom_range(1, 63));
            wrong  = ($urandom_range(0, 3) == 0);
            cks[i] = ($urandom_range(0, 3) != 0);
            exs[i] = wrong ? (core_fn(ins[i]) ^ 8'($urandom_range(1, 255))) : core_fn(ins[i]);
            if (wrong && cks[i]) begin errs++; if (first < 0) first = i; end
            load(ins[i], exs[i], cks[i], ok);
         end
         pulse_start();
         for (int i = 0; i < n; i++) begin
            tick();
            total++; if (bus.dut_instr !== ins[i]) begin bad++; $display("FAIL rnd_issue r%0d i%0d got=%0d want=%0d", r, i, bus.dut_instr, ins[i]); end
         end
         repeat (LAT) tick();
         total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rnd_done r%0d got=%0b want=1", r, bus.done); end
         total++; if (bus.err_count !== 8'(errs) || bus.err_flag !== (errs > 0)) begin
            bad++; $display("FAIL rnd_errs r%0d got=%0d want=%0d", r, bus.err_count, errs);
         end
         total++; if (bus.first_err_idx !== 16'((first < 0) ? 0 : first)) begin
            bad++; $display("FAIL rnd_first r%0d got=%0d want=%0d", r, bus.first_err_idx, (first < 0) ? 0 : first);
         end
         total++; if (bus.issue_count !== 16'(n)) begin bad++; $display("FAIL rnd_issue_count r%0d got=%0d want=%0d", r, bus.issue_count, n); end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] q [$];
      logic [5:0] want;
      int accepted = 0, extra = 0, nxt = 1, n = 0;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid  = 1'b1;
         bus.in_instr  = 6'(nxt);
         bus.in_expect = core_fn(6'(nxt));
         bus.in_check  = 1'b1;
         total++; if (bus.in_ready !== (c < DEPTH)) begin bad++; $display("FAIL bp_ready c%0d got=%0b want=%0b", c, bus.in_ready, c < DEPTH); end
         if (bus.in_ready) begin q.push_back(6'(nxt)); accepted++; nxt++; end
         tick();
      end
      total++; if (accepted != DEPTH) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", accepted, DEPTH); end
      pulse_start();
      while (!bus.done && n < 200) begin
         bus.in_valid  = (extra < 10);
         bus.in_instr  = 6'(nxt);
         bus.in_expect = core_fn(6'(nxt));
         if (bus.in_valid && bus.in_ready) begin q.push_back(6'(nxt)); extra++; nxt++; end
         tick();
         n++;
         if (bus.dut_instr != 6'd0) begin
            want = (q.size() > 0) ? q.pop_front() : 6'd0;
            total++; if (bus.dut_instr !== want) begin bad++; $display("FAIL bp_order got=%0d want=%0d", bus.dut_instr, want); end
         end
      end
      bus.in_valid = 1'b0;
      total++; if (!bus.done) begin bad++; $display("FAIL bp_timeout got=done0 want=done1"); end
      total++; if (q.size() != 0 || extra != 10) begin bad++; $display("FAIL bp_lost got=left%0d/extra%0d want=0/10", q.size(), extra); end
      total++; if (bus.issue_count !== 16'd26) begin bad++; $display("FAIL bp_issue got=%0d want=26", bus.issue_count); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL bp_errs got=%0d want=0", bus.err_count); end
   endtask

   task automatic test_empty_start();
      pulse_start();
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL empty_busy got=busy%0b/done%0b want=1/0", bus.busy, bus.done); end
      repeat (LAT) tick();
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL empty_done got=%0b want=1", bus.done); end
      total++; if (bus.issue_count !== 16'd0 || bus.err_count !== 8'd0) begin
         bad++; $display("FAIL empty_counts got=%0d/%0d want=0/0", bus.issue_count, bus.err_count);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      int pushed = 0, n = 0;
      logic [5:0] ins;
      for (int i = 0; i < DEPTH; i++) begin
         ins = 6'((pushed % 63) + 1);
         load(ins, core_fn(ins) ^ 8'hFF, 1'b1, ok);
         pushed++;
      end
      pulse_start();
      while (!bus.done && n < 1000) begin
         ins = 6'((pushed % 63) + 1);
         bus.in_valid  = (pushed < 300);
         bus.in_instr  = ins;
         bus.in_expect = core_fn(ins) ^ 8'hFF;
         bus.in_check  = 1'b1;
         if (bus.in_valid && bus.in_ready) pushed++;
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      total++; if (!bus.done) begin bad++; $display("FAIL sat_timeout got=done0 want=done1"); end
      total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d want=255", bus.err_count); end
      total++; if (bus.first_err_idx !== 16'd0 || bus.err_flag !== 1'b1) begin bad++; $display("FAIL sat_first got=%0d want=0", bus.first_err_idx); end
      total++; if (bus.issue_count !== 16'd300) begin bad++; $display("FAIL sat_issue got=%0d want=300", bus.issue_count); end
   endtask

   task automatic test_reset_midrun();
      bit ok;
      for (int i = 0; i < 8; i++) load(6'(21 + i), core_fn(6'(21 + i)), 1'b1, ok);
      pulse_start();
      tick(); tick(); tick();
      total++; if (bus.dut_instr !== 6'd23) begin bad++; $display("FAIL mid_third got=%0d want=23", bus.dut_instr); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL mid_busy got=busy%0b/done%0b want=0/0", bus.busy, bus.done); end
      total++; if (bus.dut_instr !== 6'd0) begin bad++; $display("FAIL mid_nop got=%0d want=0", bus.dut_instr); end
      total++; if (bus.issue_count !== 16'd0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL mid_state got=issue%0d/ready%0b want=0/1", bus.issue_count, bus.in_ready);
      end
      pulse_start();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_restart got=%0b want=1", bus.busy); end
      repeat (LAT) tick();
      total++; if (bus.done !== 1'b1 || bus.issue_count !== 16'd0 || bus.dut_instr !== 6'd0) begin
         bad++; $display("FAIL mid_drain got=done%0b/issue%0d want=1/0", bus.done, bus.issue_count);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_expect = '0;
      bus.in_check  = 1'b0;
      bus.start     = 1'b0;
      test_reset();
      test_pass_run();
      test_mismatch();
      test_random(6);
      test_back_to_back();
      test_empty_start();
      test_saturation();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "bench timeout");
   end

endmodule
